// File: rtl/jrb8_pkg.sv
// Shared definitions for the jrb8 CPU: SPI command codes, frame length and
// the memory-op encoding used between the control unit and spi_mem.
package jrb8_pkg;

  localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
  localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
  localparam int unsigned FRAME_BITS    = 40;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ROM_RD,
    OP_RAM_RD,
    OP_RAM_WR
  } op_t;

  // Writes win over RAM reads, which win over flash reads.
  function automatic op_t decode_op(input logic rom_read,
                                    input logic ram_read,
                                    input logic ram_write);
    if (ram_write) return OP_RAM_WR;
    if (ram_read)  return OP_RAM_RD;
    if (rom_read)  return OP_ROM_RD;
    return OP_NONE;
  endfunction

  function automatic logic [FRAME_BITS-1:0] build_frame(input op_t        op,
                                                        input logic [15:0] addr,
                                                        input logic [7:0]  data);
    logic [7:0] cmd;
    logic [7:0] payload;
    cmd     = (op == OP_RAM_WR) ? SPI_CMD_WRITE : SPI_CMD_READ;
    payload = (op == OP_RAM_WR) ? data : 8'h00;
    return {cmd, 8'h00, addr, payload};
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// 40-bit SPI datapath: parallel frame load, MSB-first shift onto mosi,
// and an 8-bit receive register filled from miso.
module spi_shift_reg
  import jrb8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  sample,
  input  logic                  clear,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  mosi,
  output logic [7:0]            rx_byte
);

  logic [FRAME_BITS-1:0] tx_q;

  // Clearing after the last bit keeps mosi low whenever the bus is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= '0;
      rx_byte <= '0;
    end else begin
      if (clear)
        tx_q <= '0;
      else if (load)
        tx_q <= frame;
      else if (shift)
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};

      if (load)
        rx_byte <= '0;
      else if (sample)
        rx_byte <= {rx_byte[6:0], miso};
    end
  end

  assign mosi = tx_q[FRAME_BITS-1];

endmodule

// File: rtl/spi_mem.sv
// SPI memory bridge: runs one 40-bit mode-0 transaction to flash or RAM per
// control-unit request, with sclk at half the system clock.
module spi_mem
  import jrb8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_executing,
  output logic        spi_done,
  input  logic        rom_read,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_rom_n,
  output logic        cs_ram_n
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    NULL,
    HOLD
  } state_t;

  // bit_cnt counts edges since acceptance minus one; odd values are falling
  // sclk edges, and the last one ends the frame.
  localparam logic [6:0] LAST_EDGE  = 7'(2 * FRAME_BITS - 1);
  localparam logic [6:0] DATA_START = 7'(2 * (FRAME_BITS - 8));

  state_t                state;
  op_t                   op_q;
  logic [6:0]            bit_cnt;
  op_t                   req_op;
  logic [FRAME_BITS-1:0] req_frame;
  logic                  sr_load;
  logic                  sr_shift;
  logic                  sr_sample;
  logic                  sr_clear;
  logic [7:0]            rx_byte;

  assign req_op    = decode_op(rom_read, ram_read, ram_write);
  assign req_frame = build_frame(req_op, address, data_in);

  assign sr_load   = (state == IDLE) && spi_executing && (req_op != OP_NONE);
  assign sr_shift  = (state == SHIFT) && bit_cnt[0] && (bit_cnt != LAST_EDGE);
  assign sr_sample = (state == SHIFT) && !bit_cnt[0] && (bit_cnt >= DATA_START) &&
                     (op_q != OP_RAM_WR);
  assign sr_clear  = (state == SHIFT) && (bit_cnt == LAST_EDGE);

  spi_shift_reg u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sr_load),
    .shift   (sr_shift),
    .sample  (sr_sample),
    .clear   (sr_clear),
    .frame   (req_frame),
    .miso    (miso),
    .mosi    (mosi),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_NONE;
      bit_cnt  <= '0;
      spi_done <= 1'b1;
      sclk     <= 1'b0;
      cs_rom_n <= 1'b1;
      cs_ram_n <= 1'b1;
      data_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (spi_executing) begin
            op_q     <= req_op;
            bit_cnt  <= '0;
            spi_done <= 1'b0;
            if (req_op == OP_NONE) begin
              state <= NULL;
            end else begin
              state    <= SHIFT;
              cs_rom_n <= (req_op != OP_ROM_RD);
              cs_ram_n <= !((req_op == OP_RAM_RD) || (req_op == OP_RAM_WR));
            end
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_EDGE) begin
            state    <= HOLD;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            cs_rom_n <= 1'b1;
            cs_ram_n <= 1'b1;
            spi_done <= 1'b1;
            if (op_q != OP_RAM_WR)
              data_out <= rx_byte;
          end else begin
            sclk    <= !bit_cnt[0];
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        NULL: begin
          spi_done <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem.sv
// Randomized bench for spi_mem: a transaction-level model predicts every pin
// each cycle, plus directed transactions with hand-computed expectations.
module tb_spi_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_executing = 1'b0;
  logic        rom_read = 1'b0;
  logic        ram_read = 1'b0;
  logic        ram_write = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        miso = 1'b0;
  logic        spi_done;
  logic [7:0]  data_out;
  logic        sclk;
  logic        mosi;
  logic        cs_rom_n;
  logic        cs_ram_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_mem dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_executing (spi_executing),
    .spi_done      (spi_done),
    .rom_read      (rom_read),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .cs_rom_n      (cs_rom_n),
    .cs_ram_n      (cs_ram_n)
  );

  task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the bench: flash is a fixed function, RAM is
  // whatever was written, defaulting to a hash of the address.
  logic [7:0] ram_mem [logic [15:0]];

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // Transaction model: kind 0=none 1=flash read 2=RAM read 3=RAM write.
  bit          m_active = 1'b0;
  bit          m_hold = 1'b0;
  int          m_n = 0;
  int          m_len = 0;
  int          m_kind = 0;
  logic [39:0] m_frame = '0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_rd = '0;
  logic [7:0]  m_data = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_hold   = 1'b0;
      m_n      = 0;
      m_data   = 8'h00;
    end else if (m_active) begin
      m_n++;
      if (m_n == m_len) begin
        m_active = 1'b0;
        m_hold   = 1'b1;
        if (m_kind == 1 || m_kind == 2) m_data = m_rd;
        else if (m_kind == 3) ram_mem[m_addr] = m_frame[7:0];
      end
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (spi_executing) begin
      m_kind   = ram_write ? 3 : ram_read ? 2 : rom_read ? 1 : 0;
      m_addr   = address;
      m_len    = (m_kind == 0) ? 1 : 80;
      m_n      = 0;
      m_active = 1'b1;
      if (m_kind == 1) m_rd = rom_byte(address);
      else m_rd = ram_mem.exists(address) ? ram_mem[address] : (address[7:0] ^ address[15:8] ^ 8'hC3);
      m_frame = {(m_kind == 3) ? 8'h02 : 8'h03, 8'h00, address, (m_kind == 3) ? data_in : 8'h00};
    end
  end

  // Memory device: presents read data during the last byte, noise otherwise.
  always @(negedge clk) begin
    int k;
    k = m_n / 2;
    if (m_active && (m_kind == 1 || m_kind == 2) && k >= 32)
      miso = m_rd[7 - (k - 32)];
    else
      miso = 1'($urandom_range(0, 1));
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_sclk, e_mosi;
    if (rst_n !== 1'bx) begin
      e_sclk = m_active && (m_kind != 0) && (m_n % 2 == 1);
      e_mosi = (m_active && m_kind != 0) ? m_frame[39 - m_n / 2] : 1'b0;
      check_output("spi_done", 40'(spi_done), 40'(!m_active));
      check_output("cs_rom_n", 40'(cs_rom_n), 40'(!(m_active && m_kind == 1)));
      check_output("cs_ram_n", 40'(cs_ram_n), 40'(!(m_active && m_kind >= 2)));
      check_output("sclk", 40'(sclk), 40'(e_sclk));
      check_output("mosi", 40'(mosi), 40'(e_mosi));
      check_output("data_out", 40'(data_out), 40'(m_data));
    end
  end

  // Issues one request at the current negedge and records the pin activity
  // of the transaction until spi_done returns high.
  task automatic apply_stimulus(input logic rr, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [7:0] din,
                                input bit hold_exec,
                                output logic [39:0] frame, output int wait_n,
                                output int low_n, output int rom_low,
                                output int ram_low, output int sclk_hi);
    spi_executing = 1'b1;
    rom_read  = rr;
    ram_read  = rd;
    ram_write = wr;
    address   = addr;
    data_in   = din;
    frame = '0; wait_n = 0; low_n = 0; rom_low = 0; ram_low = 0; sclk_hi = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (spi_done && wait_n < 20);
    check_output("accept_timeout", 40'(spi_done), 40'd0);
    if (spi_done) return;
    if (!hold_exec) spi_executing = 1'b0;
    rom_read  = 1'($urandom_range(0, 1));
    ram_read  = 1'($urandom_range(0, 1));
    ram_write = 1'($urandom_range(0, 1));
    address   = 16'($urandom);
    data_in   = 8'($urandom);
    while (!spi_done && low_n < 200) begin
      low_n++;
      if (!cs_rom_n) rom_low++;
      if (!cs_ram_n) ram_low++;
      if (sclk) begin
        sclk_hi++;
        frame = {frame[38:0], mosi};
      end
      @(negedge clk);
    end
    check_output("done_timeout", 40'(spi_done), 40'd1);
  endtask

  initial begin
    logic [39:0] fr;
    int w, lo, rl, al, sh, cnt;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_spi_done", 40'(spi_done), 40'd1);
    check_output("rst_cs", 40'({cs_rom_n, cs_ram_n}), 40'b11);
    check_output("rst_sclk_mosi", 40'({sclk, mosi}), 40'b00);
    check_output("rst_data_out", 40'(data_out), 40'h00);
    rst_n = 1'b1;

    // Flash read issued as reset releases: accepted on the very first edge.
    apply_stimulus(1, 0, 0, 16'h1234, 8'h99, 0, fr, w, lo, rl, al, sh);
    check_output("first_accept", 40'(w), 40'd1);
    check_output("rom_frame", fr, 40'h03_001234_00);
    check_output("rom_cs_low", 40'(rl), 40'd80);
    check_output("rom_cs_ram", 40'(al), 40'd0);
    check_output("rom_busy", 40'(lo), 40'd80);
    check_output("rom_sclk", 40'(sh), 40'd40);
    check_output("rom_data", 40'(data_out), 40'hA5);

    apply_stimulus(0, 0, 1, 16'hBEEF, 8'h3C, 0, fr, w, lo, rl, al, sh);
    check_output("wr_frame", fr, 40'h02_00BEEF_3C);
    check_output("wr_cs_ram", 40'(al), 40'd80);
    check_output("wr_cs_rom", 40'(rl), 40'd0);
    check_output("wr_data_kept", 40'(data_out), 40'hA5);

    // All three ops set, request held high into the next transaction.
    apply_stimulus(1, 1, 1, 16'h0042, 8'h77, 1, fr, w, lo, rl, al, sh);
    check_output("prio_frame", fr, 40'h02_000042_77);
    check_output("prio_cs_rom", 40'(rl), 40'd0);
    apply_stimulus(0, 1, 0, 16'h0042, 8'h00, 1, fr, w, lo, rl, al, sh);
    check_output("b2b_gap", 40'(w), 40'd2);
    check_output("ramrd_frame", fr, 40'h03_000042_00);
    check_output("ramrd_data", 40'(data_out), 40'h77);

    apply_stimulus(0, 0, 0, 16'h5555, 8'h55, 1, fr, w, lo, rl, al, sh);
    check_output("null_gap", 40'(w), 40'd2);
    check_output("null_low", 40'(lo), 40'd1);
    check_output("null_sclk", 40'(sh), 40'd0);
    check_output("null_cs", 40'(rl + al), 40'd0);
    check_output("null_data", 40'(data_out), 40'h77);
    apply_stimulus(0, 1, 0, 16'hBEEF, 8'h00, 0, fr, w, lo, rl, al, sh);
    check_output("null_b2b_gap", 40'(w), 40'd2);
    check_output("ram_beef", 40'(data_out), 40'h3C);

    // Reset pulsed just after edge E0+30 of a flash read.
    @(negedge clk);
    spi_executing = 1'b1; rom_read = 1'b1; ram_read = 1'b0; ram_write = 1'b0;
    address = 16'h0777;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (spi_done && cnt < 20);
    check_output("mid_accept", 40'(spi_done), 40'd0);
    spi_executing = 1'b0;
    repeat (29) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_rst_cs", 40'({cs_rom_n, cs_ram_n}), 40'b11);
    check_output("mid_rst_done", 40'(spi_done), 40'd1);
    check_output("mid_rst_sclk_mosi", 40'({sclk, mosi}), 40'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1, 0, 0, 16'h1234, 8'h00, 0, fr, w, lo, rl, al, sh);
    check_output("post_rst_frame", fr, 40'h03_001234_00);
    check_output("post_rst_data", 40'(data_out), 40'hA5);

    // Random mix of ops over a small address window so reads hit writes.
    for (int i = 0; i < 40; i++) begin
      logic rr, rd, wr;
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        spi_executing = 1'b0;
        repeat (gap) @(negedge clk);
      end
      rr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      apply_stimulus(rr, rd, wr, {8'h40, 5'b0, 3'($urandom_range(0, 7))}, 8'($urandom),
                     1'($urandom_range(0, 1)), fr, w, lo, rl, al, sh);
    end
    spi_executing = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_mem.md
SPI_MEM -- requirements
Module: spi_mem

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports listed clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL provide the control-unit handshake ports:
- spi_executing  in  1  request level from the control unit.
- spi_done  out  1  high when idle; low while a transaction runs; its rising edge marks completion.
REQ-003 SHALL provide the operation select ports, all sampled at acceptance:
- rom_read  in  1  ROMO: read one byte from flash.
- ram_read  in  1  RAMO: read one byte from RAM.
- ram_write  in  1  RAMI: write one byte to RAM.
REQ-004 SHALL provide the address and data ports:
- address  in  16  byte address, sampled at acceptance.
- data_in  in  8  write byte, sampled at acceptance.
- data_out  out  8  last byte read.
REQ-005 SHALL provide the external SPI pins:
- sclk  out  1  SPI clock, mode 0, clk/2.
- mosi  out  1  serial data to memory.
- miso  in  1  serial data from memory.
- cs_rom_n  out  1  flash chip select, active low.
- cs_ram_n  out  1  RAM chip select, active low.

Function
REQ-006 SHALL use the states IDLE, SHIFT, NULL and HOLD.
REQ-007 SHALL, in IDLE with spi_executing=1, accept a request at that edge (E0) and latch the op, address and data_in.
REQ-008 SHALL decode the op with priority ram_write > ram_read > rom_read; if none is set, go to NULL.
REQ-009 SHALL drive spi_done low from E0 until completion.
REQ-010 SHALL, for a real op, drive the selected cs_*_n low from E0 and enter SHIFT.
REQ-011 SHALL shift a 40-bit frame MSB-first: 8-bit command, 24-bit address {8'h00, address}, then 8 data bits.
REQ-012 SHALL use command 8'h03 for reads and 8'h02 for writes.
REQ-013 SHALL time bit k (0..39) as follows:
- edge E0+2k: mosi updated, sclk=0.
- edge E0+2k+1: sclk=1; miso sampled if k>=32 on a read.
REQ-014 SHALL drive mosi=0 during the data phase of reads.
REQ-015 SHALL, at edge E0+80, set sclk=0, set both chip selects high, set spi_done=1, load data_out on reads, and enter HOLD.
REQ-016 SHALL leave data_out unchanged on writes and NULL.
REQ-017 SHALL, in NULL, hold spi_done low for exactly one cycle, return it high at E0+1, and enter HOLD.
REQ-018 SHALL spend exactly one cycle in HOLD, ignoring spi_executing, then return to IDLE.
REQ-019 SHALL ignore spi_executing and all op/address/data inputs outside IDLE, including when spi_executing drops mid-transfer.
REQ-020 SHALL never assert both chip selects low at once.
REQ-021 SHALL hold sclk=0 and mosi=0 in IDLE, NULL and HOLD.

Reset
REQ-022 SHALL, on rst_n low, immediately set: state=IDLE, spi_done=1, sclk=0, mosi=0, cs_rom_n=1, cs_ram_n=1, data_out=8'h00, bit counter=0.
REQ-023 SHALL abort any in-flight transfer on reset without completing it.
REQ-024 SHALL accept a request on the first rising edge after rst_n deasserts if spi_executing=1.

Structure
REQ-025 SHALL take SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02, FRAME_BITS=40 and the op enum (OP_NONE, OP_ROM_RD, OP_RAM_RD, OP_RAM_WR) from the shared package jrb8_pkg.
REQ-026 SHALL keep the state enum local to spi_mem.
REQ-027 SHALL implement the 40-bit load/shift/sample datapath as one sub-module, spi_shift_reg, with the FSM and counter in spi_mem.

Verification
REQ-028 SHALL cover a flash read:
- stimulus: rom_read=1, address=16'h1234, memory model returns 8'hA5.
- required response: mosi frame 03_001234; cs_rom_n low for 80 cycles; spi_done rises at E0+80; data_out=8'hA5.
REQ-029 SHALL cover a RAM write:
- stimulus: ram_write=1, address=16'hBEEF, data_in=8'h3C.
- required response: frame 02_00BEEF_3C; cs_ram_n low only; data_out unchanged.
REQ-030 SHALL cover priority:
- stimulus: ram_write=ram_read=rom_read=1.
- required response: write frame; cs_rom_n stays 1.
REQ-031 SHALL cover the NULL op:
- stimulus: no op set, spi_executing=1.
- required response: spi_done low for exactly 1 cycle; no sclk edges; both chip selects stay high.
REQ-032 SHALL cover a mid-transfer reset:
- stimulus: rst_n pulsed at E0+30.
- required response: chip selects high and spi_done=1 immediately; a new read then completes correctly.
REQ-033 SHALL cover back-to-back requests:
- stimulus: spi_executing held at 1.
- required response: the next acceptance occurs exactly 2 cycles after spi_done rises.
